// File: rtl/pmem_arbiter.sv
// Round-robin arbiter that funnels several cache-side line requests onto one
// physical memory port, one transfer at a time (IDLE -> BUSY -> DONE).
module pmem_arbiter #(
   parameter int NUM_PORTS  = 2,
   parameter int ADDR_WIDTH = 16,
   parameter int LINE_WIDTH = 128
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_PORTS-1:0]            port_read,
   input  logic [NUM_PORTS-1:0]            port_write,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0] port_address,
   input  logic [NUM_PORTS*LINE_WIDTH-1:0] port_wdata,
   output logic [NUM_PORTS-1:0]            port_resp,
   output logic [LINE_WIDTH-1:0]           port_rdata,
   output logic                            pmem_read,
   output logic                            pmem_write,
   output logic [ADDR_WIDTH-1:0]           pmem_address,
   output logic [LINE_WIDTH-1:0]           pmem_wdata,
   input  logic                            pmem_resp,
   input  logic [LINE_WIDTH-1:0]           pmem_rdata
);

   localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t          state_reg, state_next;
   logic [GW-1:0]   grant_reg, grant_next;
   logic [GW-1:0]   last_grant_reg, last_grant_next;
   logic            op_write_reg, op_write_next;

   logic [NUM_PORTS-1:0]  pending;
   logic [ADDR_WIDTH-1:0] addr_arr  [NUM_PORTS];
   logic [LINE_WIDTH-1:0] wdata_arr [NUM_PORTS];
   logic [GW-1:0]         rr_sel;
   logic [GW-1:0]         rr_cand;
   logic                  rr_found;

   generate
      for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
         assign addr_arr[gi]  = port_address[gi*ADDR_WIDTH +: ADDR_WIDTH];
         assign wdata_arr[gi] = port_wdata[gi*LINE_WIDTH +: LINE_WIDTH];
         assign pending[gi]   = port_read[gi] | port_write[gi];
      end
   endgenerate

   // Search starts one past the last winner so every client gets a turn.
   always_comb begin
      rr_found = 1'b0;
      rr_sel   = '0;
      rr_cand  = '0;
      for (int k = 1; k <= NUM_PORTS; k++) begin
         rr_cand = GW'((int'(last_grant_reg) + k) % NUM_PORTS);
         if (!rr_found && pending[rr_cand]) begin
            rr_found = 1'b1;
            rr_sel   = rr_cand;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= IDLE;
         grant_reg      <= '0;
         last_grant_reg <= GW'(NUM_PORTS - 1);
         op_write_reg   <= 1'b0;
      end else begin
         state_reg      <= state_next;
         grant_reg      <= grant_next;
         last_grant_reg <= last_grant_next;
         op_write_reg   <= op_write_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      grant_next      = grant_reg;
      last_grant_next = last_grant_reg;
      op_write_next   = op_write_reg;
      pmem_read       = 1'b0;
      pmem_write      = 1'b0;
      pmem_address    = '0;
      pmem_wdata      = '0;
      port_resp       = '0;
      case (state_reg)
         IDLE: begin
            if (rr_found) begin
               state_next      = BUSY;
               grant_next      = rr_sel;
               last_grant_next = rr_sel;
               // Write wins when a client raises both strobes.
               op_write_next   = port_write[rr_sel];
            end
         end
         BUSY: begin
            pmem_read    = ~op_write_reg;
            pmem_write   = op_write_reg;
            pmem_address = addr_arr[grant_reg];
            pmem_wdata   = wdata_arr[grant_reg];
            if (pmem_resp) begin
               port_resp[grant_reg] = 1'b1;
               state_next           = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign port_rdata = pmem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter with four client ports: single reads,
// round-robin ordering, write priority, wrap-around and reset mid-transfer.
module tb_pmem_arbiter;

   localparam int NP = 4;
   localparam int AW = 16;
   localparam int LW = 128;

   logic             clk;
   logic             rst;
   logic [NP-1:0]    port_read;
   logic [NP-1:0]    port_write;
   logic [NP*AW-1:0] port_address;
   logic [NP*LW-1:0] port_wdata;
   logic [NP-1:0]    port_resp;
   logic [LW-1:0]    port_rdata;
   logic             pmem_read;
   logic             pmem_write;
   logic [AW-1:0]    pmem_address;
   logic [LW-1:0]    pmem_wdata;
   logic             pmem_resp;
   logic [LW-1:0]    pmem_rdata;

   logic [AW-1:0] addr_tab [NP];
   logic [LW-1:0] wd_tab   [NP];

   int n_cmp = 0;
   int n_err = 0;

   pmem_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
      .clk          (clk),
      .rst          (rst),
      .port_read    (port_read),
      .port_write   (port_write),
      .port_address (port_address),
      .port_wdata   (port_wdata),
      .port_resp    (port_resp),
      .port_rdata   (port_rdata),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write),
      .pmem_address (pmem_address),
      .pmem_wdata   (pmem_wdata),
      .pmem_resp    (pmem_resp),
      .pmem_rdata   (pmem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      port_address = '0;
      port_wdata   = '0;
      for (int i = 0; i < NP; i++) begin
         port_address[i*AW +: AW] = addr_tab[i];
         port_wdata[i*LW +: LW]   = wd_tab[i];
      end
   end

   task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, ".rd"},   LW'(pmem_read),    LW'(0));
      chk({tag, ".wr"},   LW'(pmem_write),   LW'(0));
      chk({tag, ".addr"}, LW'(pmem_address), LW'(0));
      chk({tag, ".wd"},   pmem_wdata,        LW'(0));
      chk({tag, ".resp"}, LW'(port_resp),    LW'(0));
   endtask

   // Entered at the negedge of an IDLE cycle with the requests already driven;
   // returns at the negedge of the DONE cycle.
   task automatic run_txn(input int port, input bit wr, input int lat,
                          input bit drop, input logic [LW-1:0] rd);
      logic [NP-1:0] exp_resp;
      #1;
      chk_quiet("idle");
      for (int c = 1; c <= lat; c++) begin
         @(negedge clk);
         if (c == lat) begin
            pmem_resp  = 1'b1;
            pmem_rdata = rd;
         end
         #1;
         exp_resp = (c == lat) ? (NP'(1) << port) : '0;
         chk("busy.rd",   LW'(pmem_read),    LW'(!wr));
         chk("busy.wr",   LW'(pmem_write),   LW'(wr));
         chk("busy.addr", LW'(pmem_address), LW'(addr_tab[port]));
         chk("busy.wd",   pmem_wdata,        wd_tab[port]);
         chk("busy.resp", LW'(port_resp),    LW'(exp_resp));
         if (c == lat) chk("rdata", port_rdata, rd);
         if (drop && c == 1) begin
            port_read  = '0;
            port_write = '0;
         end
      end
      @(negedge clk);
      pmem_resp = 1'b0;
      #1;
      chk_quiet("done");
      $display("txn port=%0d op=%s lat=%0d addr=%h", port, wr ? "WR" : "RD", lat, addr_tab[port]);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      rst        = 1'b1;
      port_read  = '0;
      port_write = '0;
      pmem_resp  = 1'b0;
      pmem_rdata = '0;
      addr_tab[0] = 16'h1230; addr_tab[1] = 16'h4560;
      addr_tab[2] = 16'h789A; addr_tab[3] = 16'hBCD0;
      wd_tab[0] = {4{32'h0A0A_0000}}; wd_tab[1] = {4{32'h1B1B_0001}};
      wd_tab[2] = {4{32'h2C2C_0002}}; wd_tab[3] = {4{32'h3D3D_0003}};

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk_quiet("reset");
      rst = 1'b0;
      @(negedge clk);

      // Single read on port 0, memory answers on the third busy cycle
      port_read = 4'b0001;
      run_txn(0, 1'b0, 3, 1'b0, {4{32'hDEAD_BEEF}});
      port_read = '0;
      @(negedge clk);

      // pmem_resp in IDLE is ignored
      pmem_resp = 1'b1;
      #1;
      chk_quiet("stray_resp");
      @(negedge clk);
      pmem_resp = 1'b0;
      #1;
      chk_quiet("stray_after");

      // Fresh reset, then ports 0 and 1 together: 0 first, then 1
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      port_read = 4'b0011;
      run_txn(0, 1'b0, 1, 1'b0, {4{32'h0000_1111}});
      port_read = 4'b0010;
      @(negedge clk);
      run_txn(1, 1'b0, 2, 1'b0, {4{32'h0000_2222}});
      port_read = '0;

      // Continuous requests from 0 and 1 alternate
      @(negedge clk);
      port_read = 4'b0011;
      for (int i = 0; i < 6; i++) begin
         run_txn(i % 2, 1'b0, 2, 1'b0, LW'(i + 16'h0100));
         if (i < 5) @(negedge clk);
      end
      port_read = '0;

      // Read and write together: write wins; dropping request mid-busy is harmless
      @(negedge clk);
      wd_tab[0]  = {16{8'hA5}};
      port_read  = 4'b0001;
      port_write = 4'b0001;
      run_txn(0, 1'b1, 3, 1'b1, {4{32'h5555_AAAA}});

      // Make port 2 the last winner, then 0 and 3 request: 3 then 0
      @(negedge clk);
      port_read = 4'b0100;
      run_txn(2, 1'b0, 1, 1'b0, {4{32'h0000_3333}});
      port_read = 4'b1001;
      @(negedge clk);
      run_txn(3, 1'b0, 2, 1'b0, {4{32'h0000_4444}});
      port_read = 4'b0001;
      @(negedge clk);
      run_txn(0, 1'b0, 1, 1'b0, {4{32'h0000_5555}});
      port_read = '0;

      // Reset mid-busy: strobes drop at once, no response, port 0 favoured after
      @(negedge clk);
      port_read = 4'b0010;
      @(negedge clk);
      #1;
      chk("pre_rst.rd",   LW'(pmem_read),    LW'(1));
      chk("pre_rst.addr", LW'(pmem_address), LW'(16'h4560));
      @(negedge clk);
      port_read = 4'b0101;
      pmem_resp = 1'b1;
      rst       = 1'b1;
      #1;
      chk_quiet("in_rst");
      @(negedge clk);
      rst       = 1'b0;
      pmem_resp = 1'b0;
      run_txn(0, 1'b0, 1, 1'b0, {4{32'h0000_6666}});
      port_read = '0;

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
